mem_rr_ctrl: RTL
================

Name: mem_rr_ctrl

Overview:
- Round-robin arbiter/sequencer that shares one single-port memory among NUM_REQ requesters.
- Requester side: per-requester command inputs with a done/err completion pulse, plus a shared read-data output.
- Memory side: drives the memory's valid/wr_rd/addr/wdata handshake and waits for ready.
- Sits between client engines and the memory instance; includes a timeout watchdog so a stalled memory cannot hang the system.

Parameters:
- WIDTH, 16, data width.
- DEPTH, 64, memory locations.
- ADDR_WIDTH, $clog2(DEPTH), address width.
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT, 16, cycles waited for mem_ready before abort; 0 disables the watchdog.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request; held until that requester's req_done.
- req_wr_rd  in  NUM_REQ  per-requester op: 1=write, 0=read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  flattened; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_REQ*WIDTH  flattened; requester i at [i*WIDTH +: WIDTH].
- req_done  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- req_err  out  1  high with req_done when the transfer was aborted by timeout.
- rdata_out  out  WIDTH  read data captured from memory; valid while req_done is high.
- grant_id  out  $clog2(NUM_REQ)  index of the current or last granted requester.
- busy  out  1  high while a transfer is outstanding.
- mem_valid  out  1  memory request valid.
- mem_wr_rd  out  1  memory op.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  WIDTH  memory write data.
- mem_rdata  in  WIDTH  memory read data.
- mem_ready  in  1  memory completion; single-cycle pulse.

Behaviour:
- Reset (async, any state): every output is 0. State = IDLE, timeout counter = 0, last_grant = NUM_REQ-1, so requester 0 has top priority after release.
- Memory protocol:
  - mem_valid/wr_rd/addr/wdata are registered and held stable from assertion until the edge at which mem_ready=1 is sampled.
  - mem_rdata is sampled on that same edge.
- FSM IDLE:
  - If any req_valid bit is set at a posedge, pick the first set bit scanning from (last_grant+1) mod NUM_REQ upward with wrap.
  - Latch that requester's wr_rd/addr/wdata into the mem_* registers, set mem_valid=1, busy=1, grant_id=pick, clear the counter, and go to ISSUE.
  - Otherwise hold; outputs unchanged except the pulse outputs, which stay 0.
- FSM ISSUE:
  - mem_ready=1 at a posedge: mem_valid←0; rdata_out←mem_rdata on reads (unchanged on writes); req_done[grant_id]←1 for one cycle; req_err←0; last_grant←grant_id; busy←0; go to IDLE.
  - mem_ready=0 and TIMEOUT≠0: counter increments each edge. On the TIMEOUT-th such edge: mem_valid←0, req_done[grant_id]←1, req_err←1, last_grant advances, go to IDLE.
  - mem_ready and timeout on the same edge: ready wins, and req_err stays 0.
- Latency: the request edge leads to mem_valid high the next cycle. The ready edge produces req_done in the following cycle. At least one IDLE cycle separates back-to-back transfers.
- The requester must drop or change req_valid in the cycle after req_done, otherwise it is re-arbitrated. Command changes after grant are ignored (already latched).
- Fairness: a continuously requesting set is served strictly in rotation; no requester waits more than NUM_REQ-1 transfers.
- Address wrap is not performed; addresses pass through unchanged, DEPTH-1 is legal.

Decomposition:
- Shared package/header mem_ctrl_pkg holds:
  - WIDTH/DEPTH defaults and the ADDR_WIDTH derivation.
  - FSM state encoding (IDLE=1'b0, ISSUE=1'b1).
  - The TIMEOUT default.
- One sub-module, rr_pick:
  - Combinational rotating-priority encoder.
  - Inputs: req vector and last_grant. Outputs: pick index and any_req.
  - The last_grant register stays in mem_rr_ctrl.

Test Plan:
- Req0 writes addr 10, data 16'hA5A5, then reads addr 10 → mem_addr=10 with mem_wr_rd=1, then 0; each request produces one req_done[0] pulse; rdata_out=16'hA5A5; req_err=0.
- All four req_valid set right after reset and each requester drops after its done → grant order 0,1,2,3; with all re-asserted, the next grant is 0.
- Req1 and req3 requesting continuously (writes to addr 5 and 7) → grants alternate 1,3,1,3; req0 and req2 are never done.
- Memory model never asserts ready, TIMEOUT=16 → mem_valid falls after 16 ISSUE edges; req_done and req_err pulse together; the next requester is granted afterwards.
- rst asserted mid-ISSUE → all outputs 0 immediately, with no clock edge needed. After release, with req2 and req0 both pending, req0 is granted first.
- Req2 writes addr 63 with 16'h1234; req0 reads addr 63 → rdata_out=16'h1234 with req_done[0].

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the round-robin memory controller.
//   - default data width, depth and watchdog timeout
//   - address width derivation from depth
//   - controller FSM state encoding
package mem_ctrl_pkg;

   localparam int unsigned WIDTH_DEF   = 16;
   localparam int unsigned DEPTH_DEF   = 64;
   localparam int unsigned TIMEOUT_DEF = 16;

   // Address bits needed for a given depth; never narrower than one bit.
   function automatic int unsigned addr_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   typedef enum logic {
      StIdle  = 1'b0,
      StIssue = 1'b1
   } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority encoder.
//   req      : request vector, one bit per requester
//   last_grant: index served most recently; scanning starts just above it
//   pick     : first set request at or after (last_grant+1) mod NUM_REQ, with wrap
//   any_req  : at least one request bit is set
module rr_pick #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IDW     = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDW-1:0]     last_grant,
   output logic [IDW-1:0]     pick,
   output logic               any_req
);

   logic [IDW-1:0] idx;

   always_comb begin
      pick    = '0;
      any_req = 1'b0;
      idx     = '0;
      // Walk from the farthest candidate to the nearest, so the nearest set bit wins.
      for (int k = int'(NUM_REQ); k > 0; k--) begin
         idx = IDW'((int'(last_grant) + k) % int'(NUM_REQ));
         if (req[idx]) begin
            pick    = idx;
            any_req = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_rr_ctrl.sv
// Round-robin sequencer sharing one single-port memory among NUM_REQ requesters.
//   Requester side: req_valid/req_wr_rd/req_addr/req_wdata in (flattened per requester),
//                   req_done (one-hot pulse), req_err (timeout abort), rdata_out,
//                   grant_id, busy.
//   Memory side:    mem_valid/mem_wr_rd/mem_addr/mem_wdata out (held until mem_ready),
//                   mem_rdata/mem_ready in.
// A watchdog aborts a transfer after TIMEOUT cycles without mem_ready (0 disables it).
module mem_rr_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH      = WIDTH_DEF,
   parameter int unsigned DEPTH      = DEPTH_DEF,
   parameter int unsigned ADDR_WIDTH = addr_width(DEPTH),
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0]            req_wr_rd,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*WIDTH-1:0]      req_wdata,
   output logic [NUM_REQ-1:0]            req_done,
   output logic                          req_err,
   output logic [WIDTH-1:0]              rdata_out,
   output logic [$clog2(NUM_REQ)-1:0]    grant_id,
   output logic                          busy,
   output logic                          mem_valid,
   output logic                          mem_wr_rd,
   output logic [ADDR_WIDTH-1:0]         mem_addr,
   output logic [WIDTH-1:0]              mem_wdata,
   input  logic [WIDTH-1:0]              mem_rdata,
   input  logic                          mem_ready
);

   localparam int unsigned IDW = $clog2(NUM_REQ);
   localparam int unsigned CW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   state_e                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [IDW-1:0]         last_grant_q, last_grant_d;
   logic [IDW-1:0]         grant_id_q, grant_id_d;
   logic                   busy_q, busy_d;
   logic                   mem_valid_q, mem_valid_d;
   logic                   mem_wr_rd_q, mem_wr_rd_d;
   logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
   logic [WIDTH-1:0]       mem_wdata_q, mem_wdata_d;
   logic [WIDTH-1:0]       rdata_q, rdata_d;
   logic [NUM_REQ-1:0]     done_q, done_d;
   logic                   err_q, err_d;

   logic [IDW-1:0]         pick;
   logic                   any_req;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDW     (IDW)
   ) u_rr_pick (
      .req        (req_valid),
      .last_grant (last_grant_q),
      .pick       (pick),
      .any_req    (any_req)
   );

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      last_grant_d = last_grant_q;
      grant_id_d   = grant_id_q;
      busy_d       = busy_q;
      mem_valid_d  = mem_valid_q;
      mem_wr_rd_d  = mem_wr_rd_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      rdata_d      = rdata_q;
      done_d       = '0;
      err_d        = 1'b0;

      case (state_q)
         StIdle: begin
            if (any_req) begin
               state_d     = StIssue;
               mem_valid_d = 1'b1;
               mem_wr_rd_d = req_wr_rd[pick];
               mem_addr_d  = req_addr[pick*ADDR_WIDTH +: ADDR_WIDTH];
               mem_wdata_d = req_wdata[pick*WIDTH +: WIDTH];
               busy_d      = 1'b1;
               grant_id_d  = pick;
               cnt_d       = '0;
            end
         end
         StIssue: begin
            // Ready takes precedence over a watchdog expiry on the same edge.
            if (mem_ready) begin
               state_d              = StIdle;
               mem_valid_d          = 1'b0;
               busy_d               = 1'b0;
               last_grant_d         = grant_id_q;
               done_d[grant_id_q]   = 1'b1;
               if (!mem_wr_rd_q) begin
                  rdata_d = mem_rdata;
               end
            end else if (TIMEOUT != 0) begin
               if (cnt_q == CW'(TIMEOUT - 1)) begin
                  state_d            = StIdle;
                  mem_valid_d        = 1'b0;
                  busy_d             = 1'b0;
                  last_grant_d       = grant_id_q;
                  done_d[grant_id_q] = 1'b1;
                  err_d              = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         last_grant_q <= IDW'(NUM_REQ - 1);
         grant_id_q   <= '0;
         busy_q       <= 1'b0;
         mem_valid_q  <= 1'b0;
         mem_wr_rd_q  <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         rdata_q      <= '0;
         done_q       <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         last_grant_q <= last_grant_d;
         grant_id_q   <= grant_id_d;
         busy_q       <= busy_d;
         mem_valid_q  <= mem_valid_d;
         mem_wr_rd_q  <= mem_wr_rd_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         rdata_q      <= rdata_d;
         done_q       <= done_d;
         err_q        <= err_d;
      end
   end

   assign req_done  = done_q;
   assign req_err   = err_q;
   assign rdata_out = rdata_q;
   assign grant_id  = grant_id_q;
   assign busy      = busy_q;
   assign mem_valid = mem_valid_q;
   assign mem_wr_rd = mem_wr_rd_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule
